// File: rtl/lcd_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter_if
// Bundles the two requester handshakes and the character-LCD pin group that
// lcd_bus_arbiter owns.
//   req0/rs0/data0 -> ack0 : requester 0 byte request and one-cycle accept
//   req1/rs1/data1 -> ack1 : requester 1 byte request and one-cycle accept
//   LCD_DATA/LCD_RS/LCD_RW/LCD_EN : HD44780-style panel pins
//   busy      : arbiter is not idle
//   init_done : power-up init sequence has finished
//   grant     : one-hot owner of the byte currently on the bus
// modport slave  : the arbiter side
// modport master : the requester / board side
// ---------------------------------------------------------------------------
interface lcd_bus_arbiter_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       busy;
  logic       init_done;
  logic [1:0] grant;

  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, LCD_DATA, LCD_RS, LCD_RW, LCD_EN, busy, init_done, grant
  );

  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, LCD_DATA, LCD_RS, LCD_RW, LCD_EN, busy, init_done, grant
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
// Owns a character-LCD bus and shares it between two byte requesters. After
// reset it waits for the panel to power up, writes a fixed four-byte init
// sequence, then accepts bytes over a req/ack handshake with round-robin
// arbitration. Each byte gets RS/DATA setup, an EN strobe, a hold time and a
// post-byte busy wait (long for clear/home, short otherwise).
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : lcd_bus_arbiter_if.slave (handshakes, LCD pins, status)
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_SHORT = 2000,
  parameter int unsigned T_LONG  = 82000,
  parameter int unsigned T_PWRUP = 750000
) (
  input logic              CLOCK_50,
  input logic              reset,
  lcd_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  // Every phase loads the shared down-counter with its length minus one and
  // leaves when the counter reads zero, so a phase of N lasts N cycles.
  localparam logic [19:0] LD_SETUP = 20'(T_SETUP - 1);
  localparam logic [19:0] LD_EN    = 20'(T_EN - 1);
  localparam logic [19:0] LD_HOLD  = 20'(T_HOLD - 1);
  localparam logic [19:0] LD_SHORT = 20'(T_SHORT - 1);
  localparam logic [19:0] LD_LONG  = 20'(T_LONG - 1);
  localparam logic [19:0] LD_PWRUP = 20'(T_PWRUP - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        init_done_q, init_done_d;
  logic        rr_last_q, rr_last_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_en_q, lcd_en_d;
  logic        busy_q, busy_d;

  logic       cnt_zero;
  logic       long_wait;
  logic       win1;
  logic [7:0] init_byte;

  assign cnt_zero = (cnt_q == 20'd0);

  // Clear display (0x01) and return home (0x02/0x03) need the long wait;
  // the byte is still on the bus when HOLD ends, so decode it from there.
  assign long_wait = !lcd_rs_q &&
                     ((lcd_data_q[7:1] == 7'b0000000) || (lcd_data_q[7:1] == 7'b0000001));

  // Tie goes to whoever did not win last time; rr_last_q==1 means
  // requester 1 won last, so requester 0 wins the next tie.
  assign win1 = bus.req1 && (!bus.req0 || !rr_last_q);

  // Init ROM: 8-bit 2-line mode, display on, clear, entry mode increment.
  always_comb begin
    init_byte = 8'h38;
    case (idx_q)
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h01;
      2'd3: init_byte = 8'h06;
      default: init_byte = 8'h38;
    endcase
  end

  // Next-state logic. Outputs are derived from the next state so that every
  // pin comes straight out of a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rr_last_d   = rr_last_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    grant_d     = grant_q;
    lcd_data_d  = lcd_data_q;
    lcd_rs_d    = lcd_rs_q;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_d = ST_INIT_LOAD;
          idx_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_INIT_LOAD: begin
        lcd_rs_d   = 1'b0;
        lcd_data_d = init_byte;
        state_d    = ST_SETUP;
        cnt_d      = LD_SETUP;
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_PULSE;
          cnt_d   = LD_EN;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_WAIT;
          cnt_d   = long_wait ? LD_LONG : LD_SHORT;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_WAIT: begin
        if (cnt_zero) begin
          if (!init_done_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT_LOAD;
          end else begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          lcd_rs_d   = win1 ? bus.rs1 : bus.rs0;
          lcd_data_d = win1 ? bus.data1 : bus.data0;
          ack0_d     = !win1;
          ack1_d     = win1;
          grant_d    = win1 ? 2'b10 : 2'b01;
          rr_last_d  = win1;
          state_d    = ST_SETUP;
          cnt_d      = LD_SETUP;
        end
      end

      default: begin
        state_d = ST_PWRUP;
        cnt_d   = LD_PWRUP;
      end
    endcase

    // Ownership ends as soon as the bus is back in IDLE.
    if (state_d == ST_IDLE) begin
      grant_d = 2'b00;
    end
  end

  assign lcd_en_d = (state_d == ST_PULSE);
  assign busy_d   = (state_d != ST_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= LD_PWRUP;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      rr_last_q   <= 1'b1;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      grant_q     <= 2'b00;
      lcd_data_q  <= 8'h00;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rr_last_q   <= rr_last_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      grant_q     <= grant_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.grant     = grant_q;
  assign bus.LCD_DATA  = lcd_data_q;
  assign bus.LCD_RS    = lcd_rs_q;
  assign bus.LCD_RW    = 1'b0;
  assign bus.LCD_EN    = lcd_en_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
// Self-checking bench for lcd_bus_arbiter with short timing parameters.
// Stimulus pushes the expected bus bytes (with their expected post-EN gap)
// and the expected ack owners into queues; a negedge monitor pops and
// compares them as EN pulses and acks appear on the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

  localparam int T_SETUP = 1;
  localparam int T_EN    = 2;
  localparam int T_HOLD  = 1;
  localparam int T_SHORT = 4;
  localparam int T_LONG  = 10;
  localparam int T_PWRUP = 20;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } byte_exp_t;

  logic clk;
  logic reset;

  lcd_bus_arbiter_if bus ();

  lcd_bus_arbiter #(
    .T_SETUP(T_SETUP),
    .T_EN   (T_EN),
    .T_HOLD (T_HOLD),
    .T_SHORT(T_SHORT),
    .T_LONG (T_LONG),
    .T_PWRUP(T_PWRUP)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  byte_exp_t exp_q[$];
  int        ack_q[$];
  int        compare_count  = 0;
  int        mismatch_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global guard so the run always ends even if the DUT wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports a line for each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Post-byte wait length as a requester would predict it from the byte.
  function automatic int wait_cycles(input logic rs, input logic [7:0] data);
    logic [6:0] upper;
    upper = data[7:1];
    if (!rs && (upper <= 7'd1)) return T_LONG;
    return T_SHORT;
  endfunction

  // ---- monitor: EN pulses, gaps, acks ----
  logic      en_prev, ack0_prev, ack1_prev, in_gap;
  int        width, gap, gap_exp, who;
  byte_exp_t exp_cur;

  always @(negedge clk) begin
    if (reset) begin
      en_prev   = 1'b0;
      ack0_prev = 1'b0;
      ack1_prev = 1'b0;
      in_gap    = 1'b0;
    end else begin
      if (bus.ack0 || bus.ack1) begin
        checkOutput("ack_dual", {31'd0, bus.ack0 & bus.ack1}, 0);
        checkOutput("ack_after_init", {31'd0, bus.init_done}, 1);
        checkOutput("ack_expected", {31'd0, ack_q.size() != 0}, 1);
        if (ack_q.size() != 0) begin
          who = ack_q.pop_front();
          checkOutput("ack_owner", {31'd0, bus.ack1}, who);
          checkOutput("ack_grant", {30'd0, bus.grant}, (who == 1) ? 2 : 1);
        end
        checkOutput("ack_width", {31'd0, (bus.ack0 & ack0_prev) | (bus.ack1 & ack1_prev)}, 0);
      end

      if (bus.LCD_EN && !en_prev) begin
        if (in_gap) begin
          checkOutput("gap_cycles", gap, gap_exp);
          in_gap = 1'b0;
        end
        checkOutput("byte_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          exp_cur = exp_q.pop_front();
          checkOutput("lcd_rs", {31'd0, bus.LCD_RS}, {31'd0, exp_cur.rs});
          checkOutput("lcd_data", {24'd0, bus.LCD_DATA}, {24'd0, exp_cur.data});
          checkOutput("lcd_rw", {31'd0, bus.LCD_RW}, 0);
          gap_exp = exp_cur.gap;
        end
        if (!bus.init_done) checkOutput("grant_init", {30'd0, bus.grant}, 0);
        width = 1;
      end else if (bus.LCD_EN) begin
        width++;
      end else if (en_prev) begin
        checkOutput("en_width", width, T_EN);
        checkOutput("hold_data", {23'd0, bus.LCD_RS, bus.LCD_DATA},
                    {23'd0, exp_cur.rs, exp_cur.data});
        in_gap = 1'b1;
        gap    = 1;
      end else if (in_gap) begin
        if (bus.busy) begin
          gap++;
        end else begin
          checkOutput("gap_cycles", gap, gap_exp);
          checkOutput("grant_idle", {30'd0, bus.grant}, 0);
          in_gap = 1'b0;
        end
      end

      en_prev   = bus.LCD_EN;
      ack0_prev = bus.ack0;
      ack1_prev = bus.ack1;
    end
  end

  // ---- stimulus helpers ----
  task automatic pushInit();
    byte_exp_t e;
    e.rs = 1'b0;
    e.data = 8'h38; e.gap = T_SHORT + 3; exp_q.push_back(e);
    e.data = 8'h0C; e.gap = T_SHORT + 3; exp_q.push_back(e);
    e.data = 8'h01; e.gap = T_LONG + 3;  exp_q.push_back(e);
    e.data = 8'h06; e.gap = T_SHORT + 1; exp_q.push_back(e);
  endtask

  task automatic doReset();
    reset    = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    ack_q.delete();
    checkOutput("rst_data", {24'd0, bus.LCD_DATA}, 0);
    checkOutput("rst_ctrl", {27'd0, bus.LCD_RS, bus.LCD_RW, bus.LCD_EN, bus.ack0, bus.ack1}, 0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 1);
    checkOutput("rst_init_done", {31'd0, bus.init_done}, 0);
    checkOutput("rst_grant", {30'd0, bus.grant}, 0);
    pushInit();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input int who_i, input logic rs, input logic [7:0] data);
    byte_exp_t e;
    logic      timed_out;
    e.rs   = rs;
    e.data = data;
    e.gap  = wait_cycles(rs, data) + T_HOLD;
    exp_q.push_back(e);
    ack_q.push_back(who_i);
    if (who_i == 0) begin
      bus.rs0 = rs; bus.data0 = data; bus.req0 = 1'b1;
    end else begin
      bus.rs1 = rs; bus.data1 = data; bus.req1 = 1'b1;
    end
    timed_out = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((who_i == 0 && bus.ack0) || (who_i == 1 && bus.ack1)) begin
        timed_out = 1'b0;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("ack_timeout", {31'd0, timed_out}, 0);
  endtask

  task automatic waitIdle();
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && ack_q.size() == 0 && !bus.busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    checkOutput("idle_timeout", {31'd0, timed_out}, 0);
    @(negedge clk);
  endtask

  task automatic waitInitDone(output int cycles, output logic timed_out);
    timed_out = 1'b1;
    cycles    = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.init_done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // ---- test sequence ----
  int   n;
  logic tmo;

  initial begin
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.rs0   = 1'b0;
    bus.data0 = 8'h00;
    bus.req1  = 1'b0;
    bus.rs1   = 1'b0;
    bus.data1 = 8'h00;

    $display("[TB] reset and power-up init");
    doReset();
    waitInitDone(n, tmo);
    checkOutput("init_timeout", {31'd0, tmo}, 0);
    checkOutput("init_cycles", n,
                T_PWRUP + 4 * (1 + T_SETUP + T_EN + T_HOLD) + 3 * T_SHORT + T_LONG);
    waitIdle();

    $display("[TB] single data byte from requester 0");
    applyStimulus(0, 1'b1, 8'h41);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    checkOutput("busy_cycles", n, T_SETUP + T_EN + T_HOLD + T_SHORT);
    waitIdle();

    $display("[TB] requester 1 home and set-address commands");
    applyStimulus(1, 1'b0, 8'h02);
    waitIdle();
    applyStimulus(1, 1'b0, 8'h80);
    waitIdle();

    $display("[TB] both requesters held together");
    begin
      byte_exp_t e;
      e.rs = 1'b1;
      for (int k = 0; k < 4; k++) begin
        e.data = (k % 2 == 0) ? 8'h30 : 8'h31;
        e.gap  = T_SHORT + T_HOLD;
        exp_q.push_back(e);
        ack_q.push_back(k % 2);
      end
    end
    bus.rs0 = 1'b1; bus.data0 = 8'h30;
    bus.rs1 = 1'b1; bus.data1 = 8'h31;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    n   = 0;
    tmo = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) n++;
      if (n == 4) begin
        tmo = 1'b0;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    checkOutput("alt_timeout", {31'd0, tmo}, 0);
    waitIdle();

    $display("[TB] request held during init");
    doReset();
    bus.rs0   = 1'b1;
    bus.data0 = 8'h45;
    bus.req0  = 1'b1;
    begin
      byte_exp_t e;
      e.rs = 1'b1; e.data = 8'h45; e.gap = T_SHORT + T_HOLD;
      exp_q.push_back(e);
      ack_q.push_back(0);
    end
    waitInitDone(n, tmo);
    checkOutput("init2_timeout", {31'd0, tmo}, 0);
    @(negedge clk);
    checkOutput("ack_first_idle", {31'd0, bus.ack0}, 1);
    bus.req0 = 1'b0;
    waitIdle();

    $display("[TB] reset during EN pulse");
    applyStimulus(1, 1'b1, 8'h52);
    tmo = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.LCD_EN) begin
        tmo = 1'b0;
        break;
      end
    end
    checkOutput("pulse_timeout", {31'd0, tmo}, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_en_drop", {31'd0, bus.LCD_EN}, 0);
    checkOutput("rst_no_ack", {30'd0, bus.ack0, bus.ack1}, 0);
    doReset();
    waitInitDone(n, tmo);
    checkOutput("init3_timeout", {31'd0, tmo}, 0);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
